// File: rtl/sigmoid_stream_ctrl.sv
// Streams a vector from the input buffer through a fixed-latency sigmoid unit
// and writes each result to the same index of the output buffer.
module sigmoid_stream_ctrl #(
  parameter int unsigned BITWIDTH    = 18,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned SIG_LATENCY = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [ADDR_W:0]     vec_len,
  output logic                busy,
  output logic                done,
  output logic                in_rd_en,
  output logic [ADDR_W-1:0]   in_addr,
  input  logic [BITWIDTH-1:0] in_data,
  output logic                act_valid,
  output logic [BITWIDTH-1:0] act_operand,
  input  logic [BITWIDTH-1:0] act_result,
  output logic                out_wr_en,
  output logic [ADDR_W-1:0]   out_addr,
  output logic [BITWIDTH-1:0] out_data
);

  localparam int unsigned D = 2 + SIG_LATENCY;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state;
  logic [ADDR_W:0]   len;
  logic [ADDR_W:0]   cnt;
  logic [D:1]        tag_v;
  logic [ADDR_W-1:0] tag_a [1:D];
  logic              kill;

  assign busy      = (state == S_ISSUE) || (state == S_DRAIN);
  assign done      = (state == S_DONE);
  assign act_valid = tag_v[2];
  assign kill      = abort && busy;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      len      <= '0;
      cnt      <= '0;
      in_rd_en <= 1'b0;
      in_addr  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            len <= vec_len;
            if (vec_len == '0) begin
              state <= S_DONE;
            end else begin
              state    <= S_ISSUE;
              in_rd_en <= 1'b1;
              in_addr  <= '0;
              cnt      <= {{ADDR_W{1'b0}}, 1'b1};
            end
          end
        end
        S_ISSUE: begin
          if (abort) begin
            state    <= S_IDLE;
            in_rd_en <= 1'b0;
          end else if (cnt == len) begin
            state    <= S_DRAIN;
            in_rd_en <= 1'b0;
          end else begin
            in_addr <= cnt[ADDR_W-1:0];
            cnt     <= cnt + 1'b1;
          end
        end
        S_DRAIN: begin
          if (abort) begin
            state <= S_IDLE;
          end else if (tag_v == '0) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // index tag rides alongside the data so writes land at the read address
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tag_v <= '0;
      for (int i = 1; i <= int'(D); i++) tag_a[i] <= '0;
    end else begin
      if (kill) tag_v <= '0;
      else      tag_v <= {tag_v[D-1:1], in_rd_en};
      tag_a[1] <= in_addr;
      for (int i = 2; i <= int'(D); i++) tag_a[i] <= tag_a[i-1];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      act_operand <= '0;
      out_wr_en   <= 1'b0;
      out_addr    <= '0;
      out_data    <= '0;
    end else begin
      if (tag_v[1]) act_operand <= in_data;
      out_wr_en <= tag_v[D] && !kill;
      if (tag_v[D]) begin
        out_addr <= tag_a[D];
        out_data <= act_result;
      end
    end
  end

endmodule

// File: tb/tb_sigmoid_stream_ctrl.sv
// Bench for sigmoid_stream_ctrl: L=1 and L=0 instances, buffer and
// sigmoid models, write scoreboard and vector table.
module tb_sigmoid_stream_ctrl;

  typedef struct {
    int len;
    int sel;
    int mask;
    int exp_done;
    int exp_wr;
    int exp_busy;
  } vec_t;

  typedef struct {
    int          addr;
    logic [17:0] data;
    int          cyc;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        abort;
  logic [8:0]  vec_len;
  logic        start0, start1;
  logic        busy0, busy1, done0, done1;
  logic        in_rd_en0, in_rd_en1, act_valid0, act_valid1;
  logic        out_wr_en0, out_wr_en1;
  logic [7:0]  in_addr0, in_addr1, out_addr0, out_addr1;
  logic [17:0] in_data0, in_data1, act_op0, act_op1;
  logic [17:0] act_res0, act_res1, out_data0, out_data1;

  logic [17:0] mem [256];
  exp_t        q[$];
  vec_t        tbl[7];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          wr_cnt, rd_cnt, busy_cnt, done_cnt, done_cyc, late;
  int          quiet_from = 32'h7fffffff;

  sigmoid_stream_ctrl #(.BITWIDTH(18), .ADDR_W(8), .SIG_LATENCY(1)) u1 (
    .clock(clock), .reset(reset), .start(start1), .abort(abort),
    .vec_len(vec_len), .busy(busy1), .done(done1),
    .in_rd_en(in_rd_en1), .in_addr(in_addr1), .in_data(in_data1),
    .act_valid(act_valid1), .act_operand(act_op1), .act_result(act_res1),
    .out_wr_en(out_wr_en1), .out_addr(out_addr1), .out_data(out_data1)
  );

  sigmoid_stream_ctrl #(.BITWIDTH(18), .ADDR_W(8), .SIG_LATENCY(0)) u0 (
    .clock(clock), .reset(reset), .start(start0), .abort(abort),
    .vec_len(vec_len), .busy(busy0), .done(done0),
    .in_rd_en(in_rd_en0), .in_addr(in_addr0), .in_data(in_data0),
    .act_valid(act_valid0), .act_operand(act_op0), .act_result(act_res0),
    .out_wr_en(out_wr_en0), .out_addr(out_addr0), .out_data(out_data0)
  );

  function automatic logic [17:0] sig_ref(input logic [17:0] x);
    logic [17:0] y;
    y = x * 18'd5;
    return y ^ 18'h15A5A;
  endfunction

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;
  always @(posedge clock) if (in_rd_en0) in_data0 <= mem[in_addr0];
  always @(posedge clock) if (in_rd_en1) in_data1 <= mem[in_addr1];
  always @(posedge clock) act_res1 <= sig_ref(act_op1);
  assign act_res0 = sig_ref(act_op0);

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic mon(input logic wr, input logic [7:0] addr,
                     input logic [17:0] data, input logic dn,
                     input logic bz, input logic rd, input logic av);
    exp_t e;
    if (wr) begin
      wr_cnt++;
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: addr %0d data 0x%0h, none expected",
                 addr, data);
      end else begin
        e = q.pop_front();
        chk("wr_addr", addr, e.addr);
        chk("wr_data", data, e.data);
        chk("wr_cycle", cyc, e.cyc);
      end
    end
    if (dn) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (bz) busy_cnt++;
    if (rd) rd_cnt++;
    if (cyc >= quiet_from && (rd || av || wr)) late++;
  endtask

  always @(negedge clock) begin
    mon(out_wr_en0, out_addr0, out_data0, done0, busy0, in_rd_en0, act_valid0);
    mon(out_wr_en1, out_addr1, out_data1, done1, busy1, in_rd_en1, act_valid1);
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic clr();
    wr_cnt = 0; rd_cnt = 0; busy_cnt = 0;
    done_cnt = 0; done_cyc = -1; late = 0;
  endtask

  task automatic launch(input int len, input int sel, output int base);
    vec_len = len[8:0];
    if (sel == 1) start1 = 1'b1;
    else          start0 = 1'b1;
    base = cyc + 1;
    for (int k = 0; k < len; k++)
      q.push_back('{k, sig_ref(mem[k]), base + 3 + sel + k});
    clr();
  endtask

  task automatic run_vec(input vec_t v);
    int base;
    int rel;
    tick();
    launch(v.len, v.sel, base);
    tick();
    start0 = 1'b0; start1 = 1'b0;
    vec_len = 9'd3;
    for (int j = 0; j < v.len + 40 && done_cnt == 0; j++) begin
      rel = cyc - base;
      if (rel >= 0 && rel < 32 && ((v.mask >> rel) & 1) == 1) begin
        if (v.sel == 1) start1 = 1'b1;
        else            start0 = 1'b1;
      end else begin
        start0 = 1'b0; start1 = 1'b0;
      end
      tick();
    end
    start0 = 1'b0; start1 = 1'b0;
    repeat (5) tick();
    chk("done_count", done_cnt, 1);
    chk("done_cycle", done_cyc - base, v.exp_done);
    chk("write_count", wr_cnt, v.exp_wr);
    chk("busy_cycles", busy_cnt, v.exp_busy);
    chk("read_count", rd_cnt, v.len);
    chk("queue_left", q.size(), 0);
    q.delete();
  endtask

  initial begin
    int base;
    reset = 1'b0; abort = 1'b0; start0 = 1'b0; start1 = 1'b0;
    vec_len = '0;
    for (int i = 0; i < 256; i++) mem[i] = 18'($urandom);
    mem[0] = 18'h00000; mem[1] = 18'h01000;
    mem[2] = 18'h3F000; mem[3] = 18'h1FFFF;
    clr();

    // len, L, extra start mask, done cycle, writes, busy cycles
    tbl[0] = '{4,   1, 0,      8,   4,   8};
    tbl[1] = '{0,   1, 0,      0,   0,   0};
    tbl[2] = '{1,   1, 0,      5,   1,   5};
    tbl[3] = '{256, 0, 0,      259, 256, 259};
    tbl[4] = '{7,   0, 0,      10,  7,   10};
    tbl[5] = '{16,  1, 0,      20,  16,  20};
    tbl[6] = '{8,   1, 32'ha,  12,  8,   12};

    repeat (2) tick();
    chk("reset_strobes",
        {busy0, busy1, done0, done1, in_rd_en0, in_rd_en1,
         act_valid0, act_valid1, out_wr_en0, out_wr_en1}, 0);
    chk("reset_addrs", {in_addr1, out_addr1, in_addr0, out_addr0}, 0);
    chk("reset_data", {out_data1, act_op1, out_data0, act_op0}, 0);
    reset = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 7; i++) begin
      if (i > 0) for (int a = 4; a < 256; a++) mem[a] = 18'($urandom);
      run_vec(tbl[i]);
    end

    tick();
    launch(16, 1, base);
    quiet_from = base + 6;
    tick();
    start1 = 1'b0;
    while (cyc < base + 5) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (12) tick();
    chk("abort_writes", wr_cnt, 2);
    chk("abort_late_strobes", late, 0);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_busy_cycles", busy_cnt, 6);
    q.delete();
    quiet_from = 32'h7fffffff;
    run_vec(tbl[0]);

    tick();
    launch(8, 1, base);
    tick();
    start1 = 1'b0;
    while (cyc < base + 3) tick();
    #2;
    reset = 1'b0;
    #1;
    chk("rst_strobes", {busy1, done1, in_rd_en1, act_valid1, out_wr_en1}, 0);
    chk("rst_in_addr", in_addr1, 0);
    chk("rst_act_operand", act_op1, 0);
    chk("rst_out", {out_addr1, out_data1}, 0);
    repeat (2) tick();
    reset = 1'b1;
    repeat (15) tick();
    chk("rst_no_write", wr_cnt, 0);
    chk("rst_no_done", done_cnt, 0);
    chk("rst_busy_cycles", busy_cnt, 4);
    q.delete();
    run_vec(tbl[2]);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
